// File: rtl/axi_ram_slave_if.sv
// axi_ram_slave_if: AXI4-subset address/data/response channels between a master and the RAM responder
interface axi_ram_slave_if #(parameter int ID_W = 4);
    logic [ID_W-1:0] arid;
    logic [31:0]     araddr;
    logic [7:0]      arlen;
    logic [2:0]      arsize;
    logic [1:0]      arburst;
    logic            arvalid;
    logic            arready;
    logic [ID_W-1:0] rid;
    logic [31:0]     rdata;
    logic [1:0]      rresp;
    logic            rlast;
    logic            rvalid;
    logic            rready;
    logic [ID_W-1:0] awid;
    logic [31:0]     awaddr;
    logic [7:0]      awlen;
    logic [2:0]      awsize;
    logic [1:0]      awburst;
    logic            awvalid;
    logic            awready;
    logic [31:0]     wdata;
    logic [3:0]      wstrb;
    logic            wlast;
    logic            wvalid;
    logic            wready;
    logic [ID_W-1:0] bid;
    logic [1:0]      bresp;
    logic            bvalid;
    logic            bready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arvalid, rready,
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        output wdata, wstrb, wlast, wvalid, bready,
        input  arready, rid, rdata, rresp, rlast, rvalid,
        input  awready, wready, bid, bresp, bvalid
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        input  wdata, wstrb, wlast, wvalid, bready,
        output arready, rid, rdata, rresp, rlast, rvalid,
        output awready, wready, bid, bresp, bvalid
    );
endinterface

// File: rtl/axi_ram_slave.sv
// axi_ram_slave: AXI4-subset responder over a word-addressed RAM, independent read and write engines
module axi_ram_slave #(
    parameter int ADDR_W = 12,
    parameter int ID_W   = 4
) (
    input logic             clk,
    input logic             reset,
    axi_ram_slave_if.slave  s
);
    typedef enum logic {R_IDLE, R_DATA} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

    r_state_t r_state, r_next;
    w_state_t w_state, w_next;

    logic [31:0] mem [2**ADDR_W];

    logic [31:0]     r_addr, w_addr, r_nxt, w_nxt;
    logic [7:0]      r_len, w_len, r_beat, w_beat;
    logic [2:0]      r_size, w_size;
    logic [1:0]      r_burst, w_burst;
    logic            r_ill, w_ill, w_err;
    logic [ID_W-1:0] w_id;
    logic            ar_hs, r_hs, aw_hs, w_hs, w_done;

    function automatic logic illegal(input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst);
        return size > 3'd2 || burst == 2'b11 ||
               (burst == 2'b10 && !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15));
    endfunction

    function automatic logic [31:0] next_addr(input logic [31:0] addr, input logic [7:0] len,
                                              input logic [2:0] size, input logic [1:0] burst);
        logic [31:0] step, mask;
        step = 32'd1 << size;
        mask = (({24'd0, len} + 32'd1) << size) - 32'd1;
        return burst == 2'b00 ? addr :
               burst == 2'b10 ? (addr & ~mask) | ((addr + step) & mask) : addr + step;
    endfunction

    assign s.arready = r_state == R_IDLE;
    assign s.awready = w_state == W_IDLE;
    assign ar_hs     = s.arready && s.arvalid;
    assign r_hs      = s.rvalid && s.rready;
    assign aw_hs     = s.awready && s.awvalid;
    assign w_hs      = s.wready && s.wvalid;
    assign w_done    = w_hs && w_beat == w_len;
    assign r_nxt     = next_addr(r_addr, r_len, r_size, r_burst);
    assign w_nxt     = next_addr(w_addr, w_len, w_size, w_burst);

    // Next-state decode for both channel engines
    always_comb begin
        r_next = r_state == R_IDLE ? (s.arvalid ? R_DATA : R_IDLE) : (r_hs && s.rlast ? R_IDLE : R_DATA);
        w_next = w_state == W_IDLE ? (s.awvalid ? W_DATA : W_IDLE) :
                 w_state == W_DATA ? (w_done ? W_RESP : W_DATA) : (s.bready ? W_IDLE : W_RESP);
    end

    // State registers; reset abandons any burst in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= R_IDLE;
            w_state <= W_IDLE;
        end else begin
            r_state <= r_next;
            w_state <= w_next;
        end
    end

    // Read datapath: latch the burst, then prefetch each beat so R outputs hold while stalled
    always_ff @(posedge clk) begin
        if (reset) begin
            s.rvalid <= 1'b0;
            s.rlast  <= 1'b0;
            s.rdata  <= '0;
            s.rid    <= '0;
            s.rresp  <= 2'b00;
        end else begin
            s.rvalid <= r_next == R_DATA;
            if (ar_hs) begin
                r_addr  <= s.araddr;
                r_len   <= s.arlen;
                r_size  <= s.arsize;
                r_burst <= s.arburst;
                r_beat  <= 8'd0;
                r_ill   <= illegal(s.arlen, s.arsize, s.arburst);
                s.rid   <= s.arid;
                s.rresp <= illegal(s.arlen, s.arsize, s.arburst) ? 2'b10 : 2'b00;
                s.rlast <= s.arlen == 8'd0;
                s.rdata <= illegal(s.arlen, s.arsize, s.arburst) ? 32'd0 : mem[s.araddr[ADDR_W+1:2]];
            end else if (r_hs && !s.rlast) begin
                r_addr  <= r_nxt;
                r_beat  <= r_beat + 8'd1;
                s.rlast <= r_beat + 8'd1 == r_len;
                s.rdata <= r_ill ? 32'd0 : mem[r_nxt[ADDR_W+1:2]];
            end else if (r_hs) begin
                s.rlast <= 1'b0;
            end
        end
    end

    // Write datapath: count beats, flag wlast disagreement, build the B response at the last beat
    always_ff @(posedge clk) begin
        if (reset) begin
            s.wready <= 1'b0;
            s.bvalid <= 1'b0;
            s.bid    <= '0;
            s.bresp  <= 2'b00;
        end else begin
            s.wready <= w_next == W_DATA;
            s.bvalid <= w_next == W_RESP;
            if (aw_hs) begin
                w_addr  <= s.awaddr;
                w_len   <= s.awlen;
                w_size  <= s.awsize;
                w_burst <= s.awburst;
                w_beat  <= 8'd0;
                w_err   <= 1'b0;
                w_ill   <= illegal(s.awlen, s.awsize, s.awburst);
                w_id    <= s.awid;
            end
            if (w_hs) begin
                w_addr <= w_nxt;
                w_beat <= w_beat + 8'd1;
                if (s.wlast != (w_beat == w_len))
                    w_err <= 1'b1;
            end
            if (w_done) begin
                s.bid   <= w_id;
                s.bresp <= (w_err || w_ill || !s.wlast) ? 2'b10 : 2'b00;
            end
        end
    end

    // RAM byte-lane writes; illegal bursts and the reset edge write nothing
    always_ff @(posedge clk) begin
        if (!reset && w_hs && !w_ill)
            for (int b = 0; b < 4; b++)
                if (s.wstrb[b])
                    mem[w_addr[ADDR_W+1:2]][8*b +: 8] <= s.wdata[8*b +: 8];
    end
endmodule

// File: tb/tb_axi_ram_slave.sv
// tb_axi_ram_slave: directed checks of bursts, strobes, wrap, errors, backpressure and reset
module tb_axi_ram_slave;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    axi_ram_slave_if #(.ID_W(4)) bus();

    axi_ram_slave #(.ADDR_W(12), .ID_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .s     (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_ar(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
        check("arready", 32'(bus.arready), 1);
        bus.arid = id; bus.araddr = addr; bus.arlen = len; bus.arsize = size; bus.arburst = burst;
        bus.arvalid = 1'b1;
        @(negedge clk);
        bus.arvalid = 1'b0;
    endtask

    task automatic do_aw(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
        check("awready", 32'(bus.awready), 1);
        bus.awid = id; bus.awaddr = addr; bus.awlen = len; bus.awsize = size; bus.awburst = burst;
        bus.awvalid = 1'b1;
        @(negedge clk);
        bus.awvalid = 1'b0;
    endtask

    task automatic do_w(input logic [31:0] data, input logic [3:0] strb, input logic last);
        check("wready", 32'(bus.wready), 1);
        bus.wdata = data; bus.wstrb = strb; bus.wlast = last; bus.wvalid = 1'b1;
        @(negedge clk);
    endtask

    task automatic finish_b(input logic [3:0] id, input logic [1:0] resp, input int stall);
        bus.wvalid = 1'b0;
        bus.wlast  = 1'b0;
        bus.bready = 1'b0;
        for (int k = 0; k < stall; k++) begin
            check("b_hold_valid", 32'(bus.bvalid), 1);
            check("b_hold_resp", 32'(bus.bresp), 32'(resp));
            @(negedge clk);
        end
        check("bvalid", 32'(bus.bvalid), 1);
        check("bid", 32'(bus.bid), 32'(id));
        check("bresp", 32'(bus.bresp), 32'(resp));
        bus.bready = 1'b1;
        @(negedge clk);
        bus.bready = 1'b0;
        check("bvalid_drop", 32'(bus.bvalid), 0);
        check("awready_back", 32'(bus.awready), 1);
    endtask

    task automatic recv(input string tag, input logic [31:0] data, input logic last,
                        input logic [1:0] resp, input logic [3:0] id);
        check({tag, "_rvalid"}, 32'(bus.rvalid), 1);
        check({tag, "_rdata"}, bus.rdata, data);
        check({tag, "_rlast"}, 32'(bus.rlast), 32'(last));
        check({tag, "_rresp"}, 32'(bus.rresp), 32'(resp));
        check({tag, "_rid"}, 32'(bus.rid), 32'(id));
        bus.rready = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arsize = '0; bus.arburst = '0; bus.arvalid = 1'b0;
        bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = '0; bus.awburst = '0; bus.awvalid = 1'b0;
        bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0;
        bus.rready = 1'b0; bus.bready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_arready", 32'(bus.arready), 1);
        check("rst_awready", 32'(bus.awready), 1);
        check("rst_rvalid", 32'(bus.rvalid), 0);
        check("rst_rlast", 32'(bus.rlast), 0);
        check("rst_rdata", bus.rdata, 0);
        check("rst_rid", 32'(bus.rid), 0);
        check("rst_rresp", 32'(bus.rresp), 0);
        check("rst_wready", 32'(bus.wready), 0);
        check("rst_bvalid", 32'(bus.bvalid), 0);
        check("rst_bid", 32'(bus.bid), 0);
        check("rst_bresp", 32'(bus.bresp), 0);
        reset = 1'b0;
        bus.wvalid = 1'b1;
        bus.wdata  = 32'hDEAD_0000;
        @(negedge clk);
        check("w_before_aw", 32'(bus.wready), 0);
        bus.wvalid = 1'b0;
        do_aw(4'h3, 32'h100, 8'd7, 3'd2, 2'b01);
        for (int i = 0; i < 8; i++)
            do_w(32'h1111_1111 * (i + 1), 4'hF, i == 7);
        finish_b(4'h3, 2'b00, 0);
        do_ar(4'h5, 32'h100, 8'd7, 3'd2, 2'b01);
        check("no_ar_overlap", 32'(bus.arready), 0);
        for (int i = 0; i < 8; i++)
            recv("incr", 32'h1111_1111 * (i + 1), i == 7, 2'b00, 4'h5);
        bus.rready = 1'b0;
        check("ar_after_r", 32'(bus.arready), 1);
        check("rvalid_after_r", 32'(bus.rvalid), 0);
        do_aw(4'h1, 32'h100, 8'd0, 3'd2, 2'b01);
        do_w(32'hAABB_CCDD, 4'hF, 1'b1);
        finish_b(4'h1, 2'b00, 0);
        do_aw(4'h1, 32'h100, 8'd0, 3'd2, 2'b01);
        do_w(32'h1122_3344, 4'b0101, 1'b1);
        finish_b(4'h1, 2'b00, 0);
        do_ar(4'h2, 32'h100, 8'd0, 3'd2, 2'b01);
        recv("strb", 32'hAA22_CC44, 1'b1, 2'b00, 4'h2);
        bus.rready = 1'b0;
        do_ar(4'h6, 32'h118, 8'd3, 3'd2, 2'b10);
        recv("wrap0", 32'h7777_7777, 1'b0, 2'b00, 4'h6);
        recv("wrap1", 32'h8888_8888, 1'b0, 2'b00, 4'h6);
        recv("wrap2", 32'h5555_5555, 1'b0, 2'b00, 4'h6);
        recv("wrap3", 32'h6666_6666, 1'b1, 2'b00, 4'h6);
        bus.rready = 1'b0;
        do_ar(4'hB, 32'h104, 8'd1, 3'd2, 2'b00);
        recv("fixed0", 32'h2222_2222, 1'b0, 2'b00, 4'hB);
        recv("fixed1", 32'h2222_2222, 1'b1, 2'b00, 4'hB);
        bus.rready = 1'b0;
        do_ar(4'h7, 32'h100, 8'd0, 3'd3, 2'b01);
        recv("err_rd", 32'h0, 1'b1, 2'b10, 4'h7);
        bus.rready = 1'b0;
        do_aw(4'h4, 32'h200, 8'd3, 3'd2, 2'b01);
        do_w(32'h1, 4'hF, 1'b0);
        do_w(32'h2, 4'hF, 1'b1);
        do_w(32'h3, 4'hF, 1'b0);
        do_w(32'h4, 4'hF, 1'b0);
        finish_b(4'h4, 2'b10, 0);
        do_aw(4'h8, 32'h300, 8'd0, 3'd2, 2'b01);
        do_w(32'hCAFE_F00D, 4'hF, 1'b1);
        finish_b(4'h8, 2'b00, 0);
        do_aw(4'h9, 32'h300, 8'd0, 3'd2, 2'b11);
        do_w(32'hDEAD_BEEF, 4'hF, 1'b1);
        finish_b(4'h9, 2'b10, 0);
        do_ar(4'h1, 32'h300, 8'd0, 3'd2, 2'b01);
        recv("suppress", 32'hCAFE_F00D, 1'b1, 2'b00, 4'h1);
        bus.rready = 1'b0;
        do_ar(4'h3, 32'h100, 8'd7, 3'd2, 2'b01);
        recv("bp0", 32'hAA22_CC44, 1'b0, 2'b00, 4'h3);
        bus.rready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            check("stall_rvalid", 32'(bus.rvalid), 1);
            check("stall_rdata", bus.rdata, 32'h2222_2222);
            check("stall_rlast", 32'(bus.rlast), 0);
            @(negedge clk);
        end
        for (int i = 1; i < 8; i++)
            recv("bp", 32'h1111_1111 * (i + 1), i == 7, 2'b00, 4'h3);
        bus.rready = 1'b0;
        do_aw(4'hA, 32'h400, 8'd1, 3'd2, 2'b01);
        do_w(32'h0BAD_F00D, 4'hF, 1'b0);
        do_w(32'h600D_F00D, 4'hF, 1'b1);
        finish_b(4'hA, 2'b00, 3);
        do_ar(4'h2, 32'h100, 8'd7, 3'd2, 2'b01);
        recv("pre_rst0", 32'hAA22_CC44, 1'b0, 2'b00, 4'h2);
        recv("pre_rst1", 32'h2222_2222, 1'b0, 2'b00, 4'h2);
        recv("pre_rst2", 32'h3333_3333, 1'b0, 2'b00, 4'h2);
        check("beat3_rdata", bus.rdata, 32'h4444_4444);
        reset = 1'b1;
        bus.rready = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        check("mid_rst_rvalid", 32'(bus.rvalid), 0);
        check("mid_rst_arready", 32'(bus.arready), 1);
        check("mid_rst_rlast", 32'(bus.rlast), 0);
        do_ar(4'h5, 32'h404, 8'd0, 3'd2, 2'b01);
        recv("post_rst", 32'h600D_F00D, 1'b1, 2'b00, 4'h5);
        bus.rready = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/axi_ram_slave.md
# axi_ram_slave

AXI4-subset responder backed by an internal word-addressed RAM. It is the memory-side end of the `simple_axi` master interface: it accepts AR/AW bursts, returns R beats, absorbs W beats and issues B responses. It is used as the bench and FPGA stand-in for the block-RAM IP behind the cache/AXI bridge. Read and write channels run independently, with one outstanding transaction per direction.

## Interface
Parameters:
- `ADDR_W`, default 12: RAM word-address bits; depth is 2^ADDR_W 32-bit words.
- `ID_W`, default 4: AXI ID width.

Ports (clock and reset first):
- `clk` in 1: sole clock; all logic is on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `arid`/`araddr`/`arlen`/`arsize`/`arburst` in ID_W/32/8/3/2: read address channel.
- `arvalid` in 1, `arready` out 1: AR handshake.
- `rid` out ID_W, `rdata` out 32, `rresp` out 2, `rlast` out 1: read data channel.
- `rvalid` out 1, `rready` in 1: R handshake.
- `awid`/`awaddr`/`awlen`/`awsize`/`awburst` in ID_W/32/8/3/2: write address channel.
- `awvalid` in 1, `awready` out 1: AW handshake.
- `wdata` in 32, `wstrb` in 4, `wlast` in 1: write data; there is no `wid`.
- `wvalid` in 1, `wready` out 1: W handshake.
- `bid` out ID_W, `bresp` out 2: write response.
- `bvalid` out 1, `bready` in 1: B handshake.

## Operation
- RAM word index is `addr[ADDR_W+1:2]`. Upper address bits are ignored, so addresses alias. The RAM is not reset.
- Burst address update per beat:
  - FIXED (00): address held.
  - INCR (01): address += 1<<size.
  - WRAP (10): INCR, wrapping within the aligned (len+1)*(1<<size) byte window. Legal len values are 1, 3, 7 and 15.
  - burst=11 is an error.
- Error conditions: size>2, burst=11, or WRAP with an illegal len. The burst still completes with the full beat count and response SLVERR (2'b10). Read data is 0 and writes are suppressed. Otherwise the response is OKAY (2'b00).
- Read FSM:
  - R_IDLE: `arready`=1. On AR handshake, latch id, addr, len, size and burst; clear the beat counter; read RAM[addr] into `rdata`; go to R_DATA.
  - R_DATA: `rvalid`=1; `rlast`=(beat==len).
    - On R handshake with beat<len: advance the address, beat+1, load the next word into `rdata`.
    - On R handshake with beat==len: go to R_IDLE.
  - `rdata`, `rid`, `rresp` and `rlast` are held stable while `rvalid`=1 and `rready`=0.
- Write FSM:
  - W_IDLE: `awready`=1. On AW handshake, latch id, addr, len, size and burst; clear the beat counter and the error flag; go to W_DATA.
  - W_DATA: `wready`=1. On each W handshake, write the bytes enabled by `wstrb` to RAM[addr], then advance the address and beat.
    - If `wlast` != (beat==len) on any beat, set the error flag.
    - The burst ends on the beat where beat==len (count-based; `wlast` is not used to end it). Then go to W_RESP.
  - W_RESP: `bvalid`=1, `bid`=latched id, `bresp`=SLVERR if the error flag is set or the burst is illegal. On B handshake, go to W_IDLE.
- Read/write collision on the same word at the same edge: the read captures the old data and the write completes.
- `arready`/`awready` are decoded from state. All other outputs are registered.

## Timing
- Reset values: `arready`=1, `awready`=1, `rvalid`=0, `rlast`=0, `rdata`=0, `rid`=0, `rresp`=0, `wready`=0, `bvalid`=0, `bid`=0, `bresp`=0.
- `reset` asserted mid-burst: both FSMs return to IDLE on the next edge. Partial writes already done remain in RAM; no B or R completion is issued.
- Read latency:
  - AR handshake at edge n gives `rvalid`=1 after edge n.
  - Each following beat is valid one edge after the previous R handshake.
  - With `rready`=1 throughout, a len+1 beat burst occupies len+1 consecutive cycles.
- The next AR is accepted in the cycle after the last R handshake; there is no AR/R overlap.
- Write: `wready` rises the cycle after the AW handshake. With `wvalid`=1 throughout, len+1 beats take len+1 cycles, and `bvalid` follows one cycle after the last W handshake.
- `bvalid` holds until `bready`. `awready` returns one cycle after the B handshake.
- W data offered before the AW handshake is not accepted (`wready`=0).

## Test plan
- Write then read back:
  - AW at 0x100, INCR, len=7, size=2; data 0x11111111..0x88888888, full strobes. Require `bresp`=00 and `bid`=awid.
  - AR at the same address. Require 8 beats matching the written data, `rlast` only on beat 7, `rresp`=00.
- Byte strobes: RAM word 0x40 = 0xAABBCCDD; single write of 0x11223344 with `wstrb`=4'b0101. A following read returns 0xAA22CC44.
- WRAP: read 0x118, len=3, size=2. Require beat addresses 0x118, 0x11C, 0x110, 0x114.
- Errors:
  - AR with size=3 gives 1 beat, `rresp`=10, `rdata`=0.
  - Write with len=3 and `wlast` on beat 1 gives `bresp`=10 after 4 beats.
- Backpressure: `rready` toggles 1,0,0,1 during a read burst and `bready`=0 for 3 cycles. Outputs stay stable while stalled; the beat count and ordering are unchanged.
- Reset mid-burst: assert `reset` during beat 3 of 8 of a read. Next cycle `rvalid`=0 and `arready`=1; a new AR completes normally.
